// File: rtl/vpu_operand_fetch_unit_pkg.sv
// Shared constants, fetch FSM states and address-field helpers for the VPU
// operand fetch unit.
package vpu_operand_fetch_unit_pkg;
  localparam int SRAM_DATA_WIDTH = 512;
  localparam int DWIDTH_PER_EXEC = 128;
  localparam int EXEC_CNT        = SRAM_DATA_WIDTH / DWIDTH_PER_EXEC;
  localparam int EXEC_CNT_LG2    = $clog2(EXEC_CNT);
  localparam int ADDR_WIDTH      = 12;
  localparam int BANK_ID_WIDTH   = 2;
  localparam int ROW_ADDR_WIDTH  = ADDR_WIDTH - BANK_ID_WIDTH;
  localparam int NUM_OPS         = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_STREAM
  } fetch_state_e;

  typedef struct packed {
    logic                      req;
    logic [BANK_ID_WIDTH-1:0]  rid;
    logic [ROW_ADDR_WIDTH-1:0] addr;
  } src_req_t;

  function automatic logic [BANK_ID_WIDTH-1:0] get_bank_id(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1 -: BANK_ID_WIDTH];
  endfunction

  function automatic logic [ROW_ADDR_WIDTH-1:0] get_row_addr(input logic [ADDR_WIDTH-1:0] a);
    return a[ROW_ADDR_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/vpu_operand_fetch_unit_if.sv
// SRAM source read port plus lane-side slice stream; master = fetch unit.
interface vpu_operand_fetch_unit_if;
  import vpu_operand_fetch_unit_pkg::*;

  logic                       src_req_o;
  logic                       src_ack_i;
  logic [BANK_ID_WIDTH-1:0]   src_rid_o;
  logic [ROW_ADDR_WIDTH-1:0]  src_addr_o;
  logic                       src_rvalid_i;
  logic [SRAM_DATA_WIDTH-1:0] src_rdata_i;
  logic                       exec_valid_o;
  logic                       exec_ready_i;
  logic [DWIDTH_PER_EXEC-1:0] exec_data0_o;
  logic [DWIDTH_PER_EXEC-1:0] exec_data1_o;
  logic                       exec_last_o;

  modport master (
    output src_req_o, src_rid_o, src_addr_o,
    input  src_ack_i, src_rvalid_i, src_rdata_i,
    output exec_valid_o, exec_data0_o, exec_data1_o, exec_last_o,
    input  exec_ready_i
  );

  modport slave (
    input  src_req_o, src_rid_o, src_addr_o,
    output src_ack_i, src_rvalid_i, src_rdata_i,
    input  exec_valid_o, exec_data0_o, exec_data1_o, exec_last_o,
    output exec_ready_i
  );
endinterface

// File: rtl/vpu_operand_fetch_unit_row_slicer.sv
// One operand row buffer; presents the cnt-selected slice of the captured row.
module vpu_operand_fetch_unit_row_slicer
  import vpu_operand_fetch_unit_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       cap,
  input  logic [SRAM_DATA_WIDTH-1:0] din,
  input  logic [EXEC_CNT_LG2-1:0]    cnt,
  output logic [DWIDTH_PER_EXEC-1:0] dout
);
  logic [EXEC_CNT-1:0][DWIDTH_PER_EXEC-1:0] row_q;

  always_ff @(posedge clk) begin
    if (rst || clr) row_q <= '0;
    else if (cap)   row_q <= din;
  end

  assign dout = row_q[cnt];
endmodule

// File: rtl/vpu_operand_fetch_unit.sv
// Fetches one or two operand rows over the SRAM read port, then streams them
// to the lane as EXEC_CNT lockstep slice pairs.
module vpu_operand_fetch_unit
  import vpu_operand_fetch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  two_src_i,
  input  logic [ADDR_WIDTH-1:0] raddr0_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  output logic                  done_o,
  vpu_operand_fetch_unit_if.master bus
);
  localparam logic [EXEC_CNT_LG2-1:0] CNT_MAX = EXEC_CNT_LG2'(EXEC_CNT - 1);

  fetch_state_e                        state_q, state_d;
  logic                                two_src_q;
  logic [NUM_OPS-1:0][ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [EXEC_CNT_LG2-1:0]             cnt_q, cnt_d;
  src_req_t                            req_q, req_d;
  logic                                valid_q, valid_d, last_q, last_d, done_d;
  logic                                start_ok, ack_ok, accept;
  logic [NUM_OPS-1:0]                  cap, clr;
  logic [NUM_OPS-1:0][DWIDTH_PER_EXEC-1:0] slice;

  assign start_ok = (state_q == S_IDLE) && start_i;
  assign ack_ok   = req_q.req && bus.src_ack_i;
  assign accept   = valid_q && bus.exec_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      two_src_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      req_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_o    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (start_ok) two_src_q <= two_src_i;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_o  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i)          state_d = S_REQ0;
      S_REQ0:   if (ack_ok)           state_d = S_WAIT0;
      S_WAIT0:  if (bus.src_rvalid_i) state_d = two_src_q ? S_REQ1 : S_STREAM;
      S_REQ1:   if (ack_ok)           state_d = S_WAIT1;
      S_WAIT1:  if (bus.src_rvalid_i) state_d = S_STREAM;
      S_STREAM: if (accept && cnt_q == CNT_MAX) state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    addr_d = addr_q;
    if (start_ok) addr_d = {raddr1_i, raddr0_i};
    cnt_d  = accept ? cnt_q + EXEC_CNT_LG2'(1) : cnt_q;
    cap[0] = (state_q == S_WAIT0) && bus.src_rvalid_i;
    cap[1] = (state_q == S_WAIT1) && bus.src_rvalid_i;
    clr[0] = 1'b0;
    clr[1] = start_ok && !two_src_i;
    req_d  = '0;
    case (state_d)
      S_REQ0, S_WAIT0: begin
        req_d.req  = (state_d == S_REQ0);
        req_d.rid  = get_bank_id(addr_d[0]);
        req_d.addr = get_row_addr(addr_d[0]);
      end
      S_REQ1, S_WAIT1: begin
        req_d.req  = (state_d == S_REQ1);
        req_d.rid  = get_bank_id(addr_d[1]);
        req_d.addr = get_row_addr(addr_d[1]);
      end
      default: ;
    endcase
    valid_d = (state_d == S_STREAM);
    last_d  = valid_d && (cnt_d == CNT_MAX);
    done_d  = (state_d == S_IDLE);
  end

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    vpu_operand_fetch_unit_row_slicer u_slicer (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr[g]),
      .cap  (cap[g]),
      .din  (bus.src_rdata_i),
      .cnt  (cnt_q),
      .dout (slice[g])
    );
  end

  assign bus.src_req_o    = req_q.req;
  assign bus.src_rid_o    = req_q.rid;
  assign bus.src_addr_o   = req_q.addr;
  assign bus.exec_valid_o = valid_q;
  assign bus.exec_last_o  = last_q;
  assign bus.exec_data0_o = slice[0];
  assign bus.exec_data1_o = slice[1];
endmodule

// File: tb/tb_vpu_operand_fetch_unit.sv
// Bench for the operand fetch unit: table of fetch transactions plus
// hand-written backpressure, ack-stall, reset and back-to-back sequences.
module tb_vpu_operand_fetch_unit;
  import vpu_operand_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst, start_i, two_src_i, done_o;
  logic [ADDR_WIDTH-1:0] raddr0_i, raddr1_i;
  always #5 clk = ~clk;

  vpu_operand_fetch_unit_if bus ();

  vpu_operand_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .two_src_i (two_src_i),
    .raddr0_i  (raddr0_i),
    .raddr1_i  (raddr1_i),
    .done_o    (done_o),
    .bus       (bus.master)
  );

  typedef logic [DWIDTH_PER_EXEC-1:0] dw_t;
  typedef struct { dw_t d0; dw_t d1; logic last; } slc_t;
  typedef struct {
    logic ts; logic [ADDR_WIDTH-1:0] a0, a1;
    logic [1:0] rid0, rid1; logic [9:0] row0, row1;
    int ad0, ad1; dw_t b0, b1; logic rnd;
  } vec_t;

  int checks = 0, failures = 0, accepted = 0;
  slc_t sbq[$];
  slc_t exp_s;
  logic prev_stall = 1'b0;
  slc_t prev_s;

  task automatic chk(input string nm, input dw_t act, input dw_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [SRAM_DATA_WIDTH-1:0] mk_row(input dw_t b);
    logic [SRAM_DATA_WIDTH-1:0] r;
    for (int i = 0; i < EXEC_CNT; i++) r[i*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] = b + dw_t'(i);
    return r;
  endfunction

  // Scoreboard side: every accepted slice is popped and compared; a stalled
  // slice must be presented unchanged on the following cycle.
  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", dw_t'(bus.exec_valid_o), 1);
        chk("hold_data0", bus.exec_data0_o, prev_s.d0);
        chk("hold_data1", bus.exec_data1_o, prev_s.d1);
        chk("hold_last", dw_t'(bus.exec_last_o), dw_t'(prev_s.last));
      end
      prev_stall = bus.exec_valid_o && !bus.exec_ready_i;
      prev_s = '{d0: bus.exec_data0_o, d1: bus.exec_data1_o, last: bus.exec_last_o};
      if (bus.exec_valid_o && bus.exec_ready_i) begin
        accepted++;
        if (sbq.size() == 0) chk("unexpected_slice", dw_t'(bus.exec_valid_o), 0);
        else begin
          exp_s = sbq.pop_front();
          chk("data0", bus.exec_data0_o, exp_s.d0);
          chk("data1", bus.exec_data1_o, exp_s.d1);
          chk("last", dw_t'(bus.exec_last_o), dw_t'(exp_s.last));
        end
      end
    end
  end

  task automatic push_exp(input logic ts, input dw_t b0, input dw_t b1);
    slc_t s;
    for (int i = 0; i < EXEC_CNT; i++) begin
      s.d0 = b0 + dw_t'(i);
      s.d1 = ts ? b1 + dw_t'(i) : '0;
      s.last = (i == EXEC_CNT - 1);
      sbq.push_back(s);
    end
  endtask

  task automatic issue(input logic ts, input logic [ADDR_WIDTH-1:0] a0, input logic [ADDR_WIDTH-1:0] a1);
    start_i = 1'b1; two_src_i = ts; raddr0_i = a0; raddr1_i = a1;
    tick();
    start_i = 1'b0; two_src_i = 1'b0; raddr0_i = '0; raddr1_i = '0;
    chk("done_busy", dw_t'(done_o), 0);
  endtask

  // Holds ack low for dly cycles (optionally pulsing start), then acks once.
  task automatic req_phase(input logic [1:0] rid, input logic [9:0] row, input int dly, input logic pulse);
    for (int k = 0; k < dly; k++) begin
      chk("req_hold", dw_t'(bus.src_req_o), 1);
      chk("rid_hold", dw_t'(bus.src_rid_o), dw_t'(rid));
      chk("addr_hold", dw_t'(bus.src_addr_o), dw_t'(row));
      if (pulse) begin start_i = k[0]; two_src_i = 1'b1; raddr0_i = 12'h111; end
      tick();
    end
    start_i = 1'b0; two_src_i = 1'b0; raddr0_i = '0;
    chk("req", dw_t'(bus.src_req_o), 1);
    chk("rid", dw_t'(bus.src_rid_o), dw_t'(rid));
    chk("addr", dw_t'(bus.src_addr_o), dw_t'(row));
    bus.src_ack_i = 1'b1;
    tick();
    bus.src_ack_i = 1'b0;
    chk("req_drop", dw_t'(bus.src_req_o), 0);
  endtask

  task automatic data_phase(input dw_t b);
    bus.src_rvalid_i = 1'b1; bus.src_rdata_i = mk_row(b);
    tick();
    bus.src_rvalid_i = 1'b0; bus.src_rdata_i = '0;
  endtask

  task automatic fetch_rows(input vec_t v, input logic pulse);
    issue(v.ts, v.a0, v.a1);
    req_phase(v.rid0, v.row0, v.ad0, pulse);
    if (!v.ts) push_exp(1'b0, v.b0, '0);
    data_phase(v.b0);
    if (v.ts) begin
      req_phase(v.rid1, v.row1, v.ad1, 1'b0);
      push_exp(1'b1, v.b0, v.b1);
      data_phase(v.b1);
    end
    chk("valid_first", dw_t'(bus.exec_valid_o), 1);
  endtask

  task automatic drain(input logic rnd);
    int n = 0;
    if (!rnd) bus.exec_ready_i = 1'b1;
    while (sbq.size() != 0 && n < 100) begin
      if (rnd) bus.exec_ready_i = ($urandom_range(0, 2) != 0);
      tick();
      n++;
    end
    bus.exec_ready_i = 1'b1;
    chk("drain_timeout", dw_t'(n < 100), 1);
    chk("done_after", dw_t'(done_o), 1);
    chk("valid_after", dw_t'(bus.exec_valid_o), 0);
    chk("last_after", dw_t'(bus.exec_last_o), 0);
  endtask

  vec_t vt[4];
  vec_t v;
  int acc0;

  initial begin
    vt[0] = '{ts:0, a0:12'h812, a1:12'h000, rid0:2, rid1:0, row0:10'h012, row1:10'h000,
              ad0:2, ad1:0, b0:128'hA, b1:128'h0, rnd:0};
    vt[1] = '{ts:1, a0:12'h005, a1:12'h406, rid0:0, rid1:1, row0:10'h005, row1:10'h006,
              ad0:0, ad1:1, b0:128'h0, b1:128'h4, rnd:0};
    vt[2] = '{ts:1, a0:12'hFFF, a1:12'h000, rid0:3, rid1:0, row0:10'h3FF, row1:10'h000,
              ad0:3, ad1:0, b0:{112'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'hFFF0},
              b1:{4'h8, 124'h0}, rnd:1};
    vt[3] = '{ts:0, a0:12'hC00, a1:12'hABC, rid0:3, rid1:0, row0:10'h000, row1:10'h000,
              ad0:0, ad1:0, b0:128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, b1:128'h0, rnd:1};

    rst = 1'b1; start_i = 1'b0; two_src_i = 1'b0; raddr0_i = '0; raddr1_i = '0;
    bus.src_ack_i = 1'b0; bus.src_rvalid_i = 1'b0; bus.src_rdata_i = '0; bus.exec_ready_i = 1'b1;
    tick(); tick();
    chk("rst_done", dw_t'(done_o), 1);
    chk("rst_req", dw_t'(bus.src_req_o), 0);
    chk("rst_valid", dw_t'(bus.exec_valid_o), 0);
    chk("rst_last", dw_t'(bus.exec_last_o), 0);
    chk("rst_rid", dw_t'(bus.src_rid_o), 0);
    chk("rst_addr", dw_t'(bus.src_addr_o), 0);
    chk("rst_data0", bus.exec_data0_o, 0);
    chk("rst_data1", bus.exec_data1_o, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      fetch_rows(vt[i], 1'b0);
      drain(vt[i].rnd);
    end

    // Backpressure on slice 1: held for three cycles, nothing skipped.
    v = '{ts:1, a0:12'h3C4, a1:12'h7E1, rid0:0, rid1:1, row0:10'h3C4, row1:10'h3E1,
          ad0:1, ad1:1, b0:128'h100, b1:128'h200, rnd:0};
    acc0 = accepted;
    bus.exec_ready_i = 1'b0;
    fetch_rows(v, 1'b0);
    bus.exec_ready_i = 1'b1;
    tick();
    bus.exec_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", dw_t'(bus.exec_valid_o), 1);
      chk("bp_data0", bus.exec_data0_o, 128'h101);
      chk("bp_data1", bus.exec_data1_o, 128'h201);
      tick();
    end
    drain(1'b0);
    chk("bp_accepted", dw_t'(accepted - acc0), 4);

    // Ack stall of 10 cycles with start pulses that must be ignored.
    v = '{ts:0, a0:12'h9AB, a1:12'h000, rid0:2, rid1:0, row0:10'h1AB, row1:10'h000,
          ad0:10, ad1:0, b0:128'h55, b1:128'h0, rnd:0};
    fetch_rows(v, 1'b1);
    drain(1'b0);

    // Reset while waiting for operand 1 data; later rvalid must be dropped.
    acc0 = accepted;
    issue(1'b1, 12'h123, 12'h456);
    req_phase(2'd0, 10'h123, 0, 1'b0);
    data_phase(128'h900);
    req_phase(2'd1, 10'h056, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", dw_t'(bus.src_req_o), 0);
    chk("mid_rst_valid", dw_t'(bus.exec_valid_o), 0);
    chk("mid_rst_done", dw_t'(done_o), 1);
    data_phase(128'h777);
    bus.src_ack_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("stray_valid", dw_t'(bus.exec_valid_o), 0);
      chk("stray_req", dw_t'(bus.src_req_o), 0);
      chk("stray_data0", bus.exec_data0_o, 0);
      tick();
    end
    bus.src_ack_i = 1'b0;
    chk("stray_accepted", dw_t'(accepted - acc0), 0);

    // Back-to-back: the second start lands the cycle after the last accept.
    v = '{ts:0, a0:12'h4AA, a1:12'h000, rid0:1, rid1:0, row0:10'h0AA, row1:10'h000,
          ad0:0, ad1:0, b0:128'h30, b1:128'h0, rnd:0};
    fetch_rows(v, 1'b0);
    drain(1'b0);
    v = '{ts:1, a0:12'h801, a1:12'hC02, rid0:2, rid1:3, row0:10'h001, row1:10'h002,
          ad0:0, ad1:0, b0:128'h40, b1:128'h50, rnd:0};
    fetch_rows(v, 1'b0);
    chk("b2b_data0_first", bus.exec_data0_o, 128'h40);
    drain(1'b0);

    chk("sb_empty", dw_t'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
